icache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller's fetch port. It acts as the initiator of the controller's fetch protocol: on a miss it requests one 32-bit word, waits for completion and fills the line. It returns instructions to IF with a fixed 1-cycle hit latency and supports pipeline-flush cancellation.

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 118 +++++++++++
 tb/tb_icache.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-controller-side signal bundle for icache
interface icache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  if_clear;
    logic                  inst_valid;
    logic [31:0]           inst;
    logic                  mc_fet_ena;
    logic [ADDR_WIDTH-1:0] mc_addr;
    logic                  mc_done;
    logic [31:0]           mc_data;

    modport slave (
        input  rdy, if_req, if_pc, if_clear, mc_done, mc_data,
        output inst_valid, inst, mc_fet_ena, mc_addr
    );

    modport master (
        output rdy, if_req, if_pc, if_clear, mc_done, mc_data,
        input  inst_valid, inst, mc_fet_ena, mc_addr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with flush cancel
module icache #(
    parameter int IDX_BITS   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = ADDR_WIDTH - IDX_BITS - 2;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t                r_state, w_state_nxt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag_mem  [LINES];
    logic [31:0]           r_data_mem [LINES];
    logic [IDX_BITS-1:0]   r_miss_idx;
    logic [TAG_W-1:0]      r_miss_tag;
    logic                  r_cancel, w_cancel_nxt;
    logic                  r_inst_valid, w_inst_valid_nxt;
    logic [31:0]           r_inst, w_inst_nxt;
    logic                  r_fet_ena, w_fet_ena_nxt;
    logic [ADDR_WIDTH-1:0] r_mc_addr, w_mc_addr_nxt;
    logic                  w_latch, w_fill;

    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_unused_pc_lsbs;

    assign w_idx            = bus.if_pc[IDX_BITS+1:2];
    assign w_tag            = bus.if_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign w_hit            = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_unused_pc_lsbs = ^bus.if_pc[1:0];

    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.mc_fet_ena = r_fet_ena;
    assign bus.mc_addr    = r_mc_addr;

    always_comb begin
        w_state_nxt      = r_state;
        w_cancel_nxt     = r_cancel;
        w_inst_valid_nxt = 1'b0;
        w_inst_nxt       = r_inst;
        w_fet_ena_nxt    = r_fet_ena;
        w_mc_addr_nxt    = r_mc_addr;
        w_latch          = 1'b0;
        w_fill           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.if_req && !bus.if_clear) begin
                    if (w_hit) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = r_data_mem[w_idx];
                    end else begin
                        w_fet_ena_nxt = 1'b1;
                        w_mc_addr_nxt = {bus.if_pc[ADDR_WIDTH-1:2], 2'b00};
                        w_latch       = 1'b1;
                        w_state_nxt   = S_MISS;
                    end
                end
            end
            S_MISS: begin
                // The controller cannot abort, so a flush only suppresses the return.
                if (bus.mc_done) begin
                    w_fill        = 1'b1;
                    w_fet_ena_nxt = 1'b0;
                    w_cancel_nxt  = 1'b0;
                    w_state_nxt   = S_IDLE;
                    if (!(r_cancel || bus.if_clear)) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = bus.mc_data;
                    end
                end else if (bus.if_clear) begin
                    w_cancel_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
            r_cancel     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_fet_ena    <= 1'b0;
            r_mc_addr    <= '0;
        end else if (bus.rdy) begin
            r_state      <= w_state_nxt;
            r_cancel     <= w_cancel_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_fet_ena    <= w_fet_ena_nxt;
            r_mc_addr    <= w_mc_addr_nxt;
            if (w_latch) begin
                r_miss_idx <= w_idx;
                r_miss_tag <= w_tag;
            end
            if (w_fill) r_valid[r_miss_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; r_valid alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && w_fill) begin
            r_data_mem[r_miss_idx] <= bus.mc_data;
            r_tag_mem[r_miss_idx]  <= r_miss_tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed and randomized self-checking bench for icache
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_if #(.ADDR_WIDTH(32)) bus ();
    icache #(.IDX_BITS(8), .ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    bit          m_valid [256];
    logic [31:0] m_addr  [256];
    logic [31:0] m_data  [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                            input int lat, input bit cancel, input int stall);
        int          idx;
        logic [31:0] wa;
        bit          hit;
        idx = int'(pc[9:2]);
        wa  = {pc[31:2], 2'b00};
        hit = m_valid[idx] && (m_addr[idx] == wa);
        bus.if_req   = 1'b1;
        bus.if_pc    = pc;
        bus.if_clear = 1'b0;
        tick();
        bus.if_req = 1'b0;
        if (hit) begin
            check("hit_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("hit_inst", bus.inst, m_data[idx]);
            check("hit_no_fetch", {31'b0, bus.mc_fet_ena}, 32'd0);
            return;
        end
        check("miss_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd1);
        check("miss_addr", bus.mc_addr, wa);
        check("miss_no_valid", {31'b0, bus.inst_valid}, 32'd0);
        if (stall > 0) begin
            bus.rdy = 1'b0;
            repeat (stall) begin
                tick();
                check("stall_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd1);
                check("stall_addr", bus.mc_addr, wa);
                check("stall_no_valid", {31'b0, bus.inst_valid}, 32'd0);
            end
            bus.rdy = 1'b1;
        end
        for (int i = 0; i < lat; i++) begin
            bus.if_clear = cancel && (i == 0);
            tick();
            bus.if_clear = 1'b0;
            check("wait_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd1);
            check("wait_addr", bus.mc_addr, wa);
            check("wait_no_valid", {31'b0, bus.inst_valid}, 32'd0);
        end
        bus.mc_done  = 1'b1;
        bus.mc_data  = data;
        bus.if_clear = cancel && (lat == 0);
        tick();
        bus.mc_done  = 1'b0;
        bus.if_clear = 1'b0;
        check("done_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd0);
        check("done_valid", {31'b0, bus.inst_valid}, {31'b0, !cancel});
        if (!cancel) check("done_inst", bus.inst, data);
        m_valid[idx] = 1'b1;
        m_addr[idx]  = wa;
        m_data[idx]  = data;
        tick();
        check("valid_pulse", {31'b0, bus.inst_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;
        rst          = 1'b1;
        bus.rdy      = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_pc    = '0;
        bus.if_clear = 1'b0;
        bus.mc_done  = 1'b0;
        bus.mc_data  = '0;
        model_clear();
        repeat (2) tick();
        check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd0);
        check("rst_mc_addr", bus.mc_addr, 32'd0);
        rst = 1'b0;
        tick();

        do_fetch(32'h4, 32'h00A00093, 2, 1'b0, 0);
        do_fetch(32'h4, 32'h0, 0, 1'b0, 0);
        do_fetch(32'h404, mem_word(32'h404), 1, 1'b0, 0);
        do_fetch(32'h4, 32'h00A00093, 1, 1'b0, 0);
        do_fetch(32'h8, 32'h12345678, 3, 1'b1, 0);
        do_fetch(32'h8, 32'h0, 0, 1'b0, 0);
        do_fetch(32'hC, 32'hDEADBEEF, 0, 1'b1, 0);
        do_fetch(32'hC, 32'h0, 0, 1'b0, 0);
        do_fetch(32'h10, 32'hCAFEF00D, 2, 1'b0, 5);
        do_fetch(32'h10, 32'h0, 0, 1'b0, 0);

        bus.if_req = 1'b1;
        bus.if_pc  = 32'h20;
        tick();
        bus.if_req = 1'b0;
        check("rstmiss_fet_ena", {31'b0, bus.mc_fet_ena}, 32'd1);
        rst = 1'b1;
        tick();
        check("rstmiss_drop", {31'b0, bus.mc_fet_ena}, 32'd0);
        check("rstmiss_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rstmiss_addr", bus.mc_addr, 32'd0);
        rst = 1'b0;
        model_clear();
        tick();
        do_fetch(32'h4, 32'h00A00093, 1, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            pc = {20'($urandom_range(0, 3)), 2'b00, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            do_fetch(pc, mem_word({pc[31:2], 2'b00}), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
